// File: rtl/modred_wlm.sv
// modred_wlm: iterative word-level Montgomery reduction, C = T*2^(-N*K) mod q,
// for moduli of the form q = qH*2^K + 1.
module modred_wlm #(
  parameter int LOGQ  = 64,
  parameter int LOGQH = 47
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2*LOGQ-1:0]   T,
  input  logic [LOGQH-1:0]    qH,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [LOGQ-1:0]     C
);
  localparam int K   = LOGQ - LOGQH;
  localparam int N   = (LOGQ + K - 1) / K;
  localparam int LAT = N + 1;
  localparam int WW  = 2 * LOGQ + 1;
  localparam int CW  = $clog2(LAT);
  typedef enum logic [1:0] {IDLE, ITER, FINAL, DONE} state_t;
  state_t             state_q, state_d;
  logic [WW-1:0]      w_q, w_d;
  logic [LOGQH-1:0]   qh_q, qh_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [LOGQ-1:0]    c_q, c_d;
  logic               ov_q, ov_d;
  logic [LOGQ-1:0]    q;
  logic [K-1:0]       l, m;
  logic [K+LOGQH-1:0] prod;
  logic [WW-1:0]      step, q_w;
  logic [LOGQ-1:0]    fin;
  // -q^-1 == -1 mod 2^K, so the Montgomery digit is just the negated low word
  assign q    = {qh_q, {(K-1){1'b0}}, 1'b1};
  assign q_w  = {{(LOGQ+1){1'b0}}, q};
  assign l    = w_q[K-1:0];
  assign m    = -l;
  assign prod = {{LOGQH{1'b0}}, m} * {{K{1'b0}}, qh_q};
  assign step = (w_q >> K) + {{(LOGQ+1){1'b0}}, prod} + {{(WW-1){1'b0}}, |l};
  assign fin  = w_q[LOGQ-1:0] - q;
  assign in_ready  = (state_q == IDLE);
  assign out_valid = ov_q;
  assign C         = c_q;
  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    qh_d    = qh_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    ov_d    = ov_q;
    case (state_q)
      IDLE: if (in_valid) begin
        w_d     = {1'b0, T};
        qh_d    = qH;
        cnt_d   = '0;
        state_d = ITER;
      end
      ITER: begin
        w_d     = step;
        cnt_d   = cnt_q + CW'(1);
        state_d = (cnt_q == CW'(N - 1)) ? FINAL : ITER;
      end
      FINAL: begin
        c_d     = (w_q >= q_w) ? fin : w_q[LOGQ-1:0];
        ov_d    = 1'b1;
        state_d = DONE;
      end
      DONE: if (out_ready) begin
        ov_d    = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      w_q     <= '0;
      qh_q    <= '0;
      cnt_q   <= '0;
      c_q     <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      qh_q    <= qh_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      ov_q    <= ov_d;
    end
  end
endmodule

// File: tb/tb_modred_wlm.sv
// tb_modred_wlm: directed vectors plus handshake, reset and randomized checks
// for modred_wlm at default parameters.
module tb_modred_wlm;
  localparam logic [46:0]  QH   = 47'h400008C00000;
  localparam logic [63:0]  Q    = 64'h8000118000000001;
  localparam logic [127:0] Q128 = {64'd0, Q};
  localparam logic [127:0] ONE  = 128'd1;
  typedef struct {
    logic [127:0] t;
    logic [63:0]  c;
  } vec_t;
  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready;
  logic [127:0] T;
  logic [46:0]  qH;
  logic [63:0]  C;
  int checks = 0;
  int failures = 0;
  modred_wlm dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .T(T), .qH(qH), .out_valid(out_valid), .out_ready(out_ready), .C(C)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  // independent reference: reduce mod q, then halve 68 times modulo q
  function automatic logic [63:0] ref_c(input logic [127:0] t);
    logic [64:0] r;
    r = 65'(t % Q128);
    for (int i = 0; i < 68; i++) r = r[0] ? (r + {1'b0, Q}) >> 1 : r >> 1;
    return r[63:0];
  endfunction
  task automatic wait_ov(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
  endtask
  task automatic op(input logic [127:0] t, input logic [63:0] exp, input string nm, output logic [63:0] got);
    int n;
    chk({nm, " in_ready"}, 128'(in_ready), 128'd1);
    T = t;
    qH = QH;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    T = '1;
    qH = '0;
    wait_ov(n);
    chk({nm, " latency"}, 128'(n), 128'd5);
    chk({nm, " C"}, 128'(C), 128'(exp));
    got = C;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({nm, " release"}, 128'({in_ready, out_valid}), 128'd2);
  endtask
  initial begin
    vec_t tv[8];
    logic [63:0]  got, a, b;
    logic [127:0] t;
    int n, acc0, acc1;
    tv[0] = '{128'd0, 64'd0};
    tv[1] = '{ONE << 68, 64'd1};
    tv[2] = '{ONE << 127, 64'h0800000000000000};
    tv[3] = '{Q128, 64'd0};
    tv[4] = '{Q128 + (ONE << 68), 64'd1};
    tv[5] = '{128'h0123456789ABCDEF << 68, 64'h0123456789ABCDEF};
    tv[6] = '{(Q128 << 63) + (128'd7 << 68), 64'd7};
    tv[7] = '{(Q128 << 5) - (ONE << 68), Q - 64'd1};
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    T = '0;
    qH = QH;
    tick();
    tick();
    chk("reset in_ready", 128'(in_ready), 128'd1);
    chk("reset out_valid", 128'(out_valid), 128'd0);
    chk("reset C", 128'(C), 128'd0);
    rst = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) op(tv[i].t, tv[i].c, $sformatf("vec%0d", i), got);
    // backpressure with ignored in_valid pulses during ITER
    T = ONE << 68;
    qH = QH;
    in_valid = 1'b1;
    tick();
    T = '0;
    tick();
    tick();
    in_valid = 1'b0;
    wait_ov(n);
    chk("bp latency", 128'(n), 128'd3);
    for (int i = 0; i < 3; i++) begin
      chk("bp hold", 128'({out_valid, in_ready, C}), {62'd0, 2'b10, 64'd1});
      tick();
    end
    chk("bp still valid", 128'({out_valid, C}), {63'd0, 1'b1, 64'd1});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp release", 128'({in_ready, out_valid}), 128'd2);
    // back-to-back operations with out_ready held high
    T = 128'd3 << 68;
    qH = QH;
    in_valid = 1'b1;
    out_ready = 1'b1;
    acc0 = -1;
    acc1 = -1;
    for (int i = 0; i < 20; i++) begin
      if (in_ready) begin
        if (acc0 < 0) acc0 = i;
        else if (acc1 < 0) acc1 = i;
      end
      if (out_valid) chk("b2b C", 128'(C), 128'd3);
      tick();
    end
    in_valid = 1'b0;
    chk("b2b interval", 128'(acc1 - acc0), 128'd7);
    out_ready = 1'b0;
    wait_ov(n);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("b2b drain", 128'(in_ready), 128'd1);
    // reset during the second ITER cycle
    T = ONE << 68;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst state", 128'({out_valid, in_ready, C}), {62'd0, 2'b01, 64'd0});
    op(ONE << 68, 64'd1, "post_rst", got);
    // out-of-range input: result unspecified but the FSM must recover
    T = '1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_ov(n);
    chk("illegal latency", 128'(n), 128'd5);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("illegal recover", 128'(in_ready), 128'd1);
    t = (Q128 << 64) - ONE;
    op(t, ref_c(t), "max_legal", got);
    t = (Q128 - ONE) * (Q128 - ONE);
    op(t, ref_c(t), "max_prod", got);
    for (int i = 0; i < 16; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      if (a >= Q) a = a - Q;
      if (b >= Q) b = b - Q;
      t = 128'(a) * 128'(b);
      op(t, ref_c(t), $sformatf("rand%0d", i), got);
      chk($sformatf("rand%0d range", i), 128'(got < Q), 128'd1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/modred_wlm.md
# modred_wlm

Iterative word-level Montgomery reduction for the special modulus family q = qH·2^K + 1, where K = LOGQ − LOGQH. It turns a double-width product T into C = T·2^(−N·K) mod q, fully reduced into [0, q). It sits directly upstream of modsub and supplies operands already in [0, q). Input and output use valid/ready handshakes, and it processes one reduction at a time.

## Interface
- LOGQ, 64, modulus width in bits; q < 2^LOGQ.
- LOGQH, 47, width of qH; the modulus is q = {qH, (K−1)'b0, 1'b1}.
- K (localparam), LOGQ − LOGQH, word size reduced per iteration (17 at defaults).
- N (localparam), ceil(LOGQ / K), iteration count (4 at defaults).
- LAT (localparam), N + 1, cycles from input accept to out_valid (5 at defaults).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  T and qH are valid.
- in_ready  out  1  high only in IDLE.
- T  in  2·LOGQ  operand; must satisfy T < q·2^LOGQ.
- qH  in  LOGQH  upper modulus bits; sampled on accept.
- out_valid  out  1  C is valid.
- out_ready  in  1  consumer accepts C.
- C  out  LOGQ  result, T·2^(−N·K) mod q, in [0, q).

## Operation
- Datapath:
  - Working register W is 2·LOGQ + 1 bits wide.
  - Registered copies of qH and q are captured at accept.
- Iteration step (−q⁻¹ ≡ −1 mod 2^K):
  - l = W[K−1:0].
  - m = (2^K − l) mod 2^K.
  - c = (l ≠ 0).
  - W ← (W >> K) + m·qH + c. This equals (W + m·q)/2^K exactly.
  - No generic multiplier by q is used; only the K×LOGQH product m·qH.
- Bound: with T < q·2^(N·K), every step keeps W < 2^(2·LOGQ+1). After N steps, W < 2q.
- Final step: C ← (W ≥ q) ? W − q : W, truncated to LOGQ bits.
- FSM states and transitions:
  - IDLE: in_ready = 1. On in_valid, capture W ← {1'b0, T}, latch qH, clear cnt, go to ITER.
  - ITER: perform one step per cycle and increment cnt. After the N-th step (cnt = N−1), go to FINAL.
  - FINAL: perform the conditional subtract, register C, set out_valid ← 1, go to DONE.
  - DONE: hold C and out_valid stable. When out_ready = 1 at an edge, clear out_valid and go to IDLE.
- in_valid outside IDLE is ignored. T and qH may change freely while the block is busy.
- Inputs with T ≥ q·2^LOGQ are illegal. The output for such inputs is unspecified, but the FSM must still return to IDLE.

## Timing
- Reset values: state = IDLE, in_ready = 1, out_valid = 0, C = 0, cnt = 0, W = 0.
- Reset takes priority over everything. Asserting rst in any state, including mid-ITER or DONE with out_valid high, aborts the operation and discards the result. The block is back in IDLE on the next cycle.
- Accept happens at edge e with in_valid & in_ready.
  - N iterations run on edges e+1 … e+N.
  - FINAL runs on edge e+N+1, so out_valid is high starting LAT = N+1 cycles after accept.
- Output handshake occurs at edge f with out_valid & out_ready.
  - out_valid drops after f.
  - in_ready rises after f. A new accept is possible at edge f+1 at the earliest.
- Minimum initiation interval is N + 3 cycles (7 at defaults).
- out_ready held high while waiting: the result is released on the first DONE cycle.
- out_ready low: C stays constant indefinitely.
- in_ready is a combinational decode of state == IDLE.

## Test plan
All cases use defaults with qH = 47'h400008C00000, so q = 64'h8000118000000001.

1. **T = 0.** Expect C = 0. out_valid rises exactly 5 cycles after accept.
2. **T = 2^68.** Expect C = 1. Also T = 2^127, expecting C = 64'h0800000000000000.
3. **T = q.** Expect C = 0. Also T = q + 2^68, expecting C = 1; this exercises the final subtract.
4. **Backpressure and ignored input.** Hold out_ready low for 3 cycles after out_valid.
   - Expect C and out_valid stable and in_ready = 0.
   - in_valid pulses during ITER are ignored.
   - Raise out_ready: one transfer occurs, in_ready rises the next cycle, and back-to-back ops have a 7-cycle interval.
5. **Reset mid-operation.** Assert rst during the 2nd ITER cycle.
   - Next cycle: out_valid = 0, in_ready = 1, C = 0.
   - A following T = 2^68 still returns C = 1.
6. **Randomized check.** Random A, B < q with T = A·B, compared against a reference model of A·B·2^(−68) mod q. Every C must be < q, then fed into modsub.
